// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - execute stage that walks the instruction register and emits results
module instr_exec_unit #(
    parameter int FIRST_PTR_W = 5,
    parameter int RESULT_W    = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [FIRST_PTR_W-1:0]     start_ptr,
    input  logic [FIRST_PTR_W:0]       num_instr,
    output logic [FIRST_PTR_W-1:0]     read_pointer,
    input  logic [67:0]                instruction_word,
    output logic signed [RESULT_W-1:0] result,
    output logic [3:0]                 result_opcode,
    output logic [FIRST_PTR_W-1:0]     result_ptr,
    output logic                       result_err,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT,
        S_DONE
    } state_e;

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    state_e                       state_q;
    logic [FIRST_PTR_W-1:0]       start_ptr_q;
    logic [FIRST_PTR_W:0]         num_q;
    logic [FIRST_PTR_W:0]         count_q;
    logic [FIRST_PTR_W:0]         count_d;
    logic [FIRST_PTR_W-1:0]       read_pointer_q;
    logic [67:0]                  instr_q;
    logic signed [RESULT_W-1:0]   result_q;
    logic [3:0]                   result_opcode_q;
    logic [FIRST_PTR_W-1:0]       result_ptr_q;
    logic                         result_err_q;
    logic                         result_valid_q;
    logic                         busy_q;
    logic                         done_q;

    logic [3:0]                   opc;
    logic signed [RESULT_W-1:0]   a_ext;
    logic signed [RESULT_W-1:0]   b_ext;
    logic signed [RESULT_W-1:0]   result_d;
    logic                         err_d;

    // Operands are widened before every operation so ADD/SUB/MULT/DIV never wrap,
    // including the INT_MIN / -1 quotient.
    always_comb begin
        opc      = instr_q[67:64];
        a_ext    = {{(RESULT_W-32){instr_q[63]}}, instr_q[63:32]};
        b_ext    = {{(RESULT_W-32){instr_q[31]}}, instr_q[31:0]};
        result_d = '0;
        err_d    = 1'b0;
        case (opc)
            OPC_ZERO:  result_d = '0;
            OPC_PASSA: result_d = a_ext;
            OPC_PASSB: result_d = b_ext;
            OPC_ADD:   result_d = a_ext + b_ext;
            OPC_SUB:   result_d = a_ext - b_ext;
            OPC_MULT:  result_d = a_ext * b_ext;
            OPC_DIV: begin
                if (b_ext == '0) err_d = 1'b1;
                else             result_d = a_ext / b_ext;
            end
            OPC_MOD: begin
                if (b_ext == '0) err_d = 1'b1;
                else             result_d = a_ext % b_ext;
            end
            default:   err_d = 1'b1;
        endcase
    end

    assign count_d = count_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            start_ptr_q     <= '0;
            num_q           <= '0;
            count_q         <= '0;
            read_pointer_q  <= '0;
            instr_q         <= '0;
            result_q        <= '0;
            result_opcode_q <= '0;
            result_ptr_q    <= '0;
            result_err_q    <= 1'b0;
            result_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        start_ptr_q <= start_ptr;
                        num_q       <= num_instr;
                        count_q     <= '0;
                        busy_q      <= 1'b1;
                        if (num_instr == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q        <= S_FETCH;
                            read_pointer_q <= start_ptr;
                        end
                    end
                end
                S_FETCH: begin
                    instr_q <= instruction_word;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    result_q        <= result_d;
                    result_opcode_q <= opc;
                    result_ptr_q    <= read_pointer_q;
                    result_err_q    <= err_d;
                    result_valid_q  <= 1'b1;
                    state_q         <= S_OUT;
                end
                S_OUT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        count_q        <= count_d;
                        if (count_d == num_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q        <= S_FETCH;
                            read_pointer_q <= start_ptr_q + count_d[FIRST_PTR_W-1:0];
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign read_pointer  = read_pointer_q;
    assign result        = result_q;
    assign result_opcode = result_opcode_q;
    assign result_ptr    = result_ptr_q;
    assign result_err    = result_err_q;
    assign result_valid  = result_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: doc/instr_exec_unit.md
# instr_exec_unit

Execute stage that sits directly downstream of the instruction register. On `start` it walks `read_pointer` over a contiguous run of register entries, captures each `instruction_word`, computes the opcode's result and presents it on a valid/ready output port. It is the consumer of what the register stores: it replaces the bench reading entries back for checking with real in-design execution.

## Interface
- `FIRST_PTR_W`, 5: width of `read_pointer`/`start_ptr`; the register depth is 32 entries.
- `RESULT_W`, 64: signed result width; holds the full product of two 32-bit operands.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `start_ptr`  in  5  first register address of the run.
- `num_instr`  in  6  instructions in the run, 0..32.
- `read_pointer`  out  5  address driven to the instruction register.
- `instruction_word`  in  68  {opc[3:0], op_a signed[31:0], op_b signed[31:0]}; combinational read of entry `read_pointer`.
- `result`  out  64  signed result.
- `result_opcode`  out  4  opcode that produced `result`.
- `result_ptr`  out  5  address the instruction was read from.
- `result_err`  out  1  divide/mod by zero, or illegal opcode.
- `result_valid`  out  1  output holds a result.
- `result_ready`  in  1  downstream accepts the result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the run ends.

## Operation
States and transitions:
- IDLE: when `start` is high, latch `start_ptr` and `num_instr` and clear the count; go to FETCH. If `num_instr`==0, go to DONE instead.
- FETCH: `read_pointer` = `start_ptr` + count (mod 32). Register `instruction_word`; go to EXEC.
- EXEC: compute the result and register it together with the opcode, pointer and err; go to OUT.
- OUT: `result_valid`=1. All result outputs hold stable until `result_ready`=1. On the handshake the count increments; if the count reaches `num_instr`, go to DONE, else go to FETCH.
- DONE: `done`=1 for one cycle; go to IDLE.

Opcode semantics (operands signed 32-bit, result sign-extended to 64 bits):
- 0 ZERO → 0.
- 1 PASSA → op_a.
- 2 PASSB → op_b.
- 3 ADD → op_a+op_b, computed at 33 bits, no wrap.
- 4 SUB → op_a−op_b, computed at 33 bits.
- 5 MULT → op_a*op_b, full 64 bits.
- 6 DIV → op_a/op_b, truncates toward zero.
- 7 MOD → op_a%op_b; the sign follows op_a.
- DIV or MOD with op_b==0 → result 0, `result_err`=1.
- Opcodes 8..15 are illegal → result 0, `result_err`=1.
- `start` while `busy` is ignored.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` effect on release): state IDLE; `read_pointer`, `result`, `result_opcode`, `result_ptr`, `result_err`, `result_valid`, `busy`, `done` all 0.
- `start` sampled at edge 0 → FETCH in cycle 1 → EXEC in cycle 2 → `result_valid`=1 from cycle 3.
- Peak throughput is one result per 3 cycles when `result_ready` is held high.
- `read_pointer` changes only on entry to FETCH; otherwise it holds its last value.
- The run wraps past address 31 to 0. The count runs 0..32 in 6 bits; a run of 32 visits every entry exactly once.
- `done` is asserted the cycle after the final handshake, so a run of N instructions with `result_ready` always high ends with `done` at cycle 3N+1 relative to the start edge.
- Reset asserted mid-run aborts immediately: any pending result is dropped and no `done` is produced.
- `result_ready` high outside OUT has no effect.

## Test plan
- Reset check: assert `reset_n`=0 mid-EXEC → all outputs 0 and state IDLE within the same cycle; after release, `start` is accepted normally.
- Full opcode sweep: load 8 entries at ptr 0 with op_a=−7, op_b=2, opcodes 0..7; run with `start_ptr`=0, `num_instr`=8, `result_ready`=1 → results 0, −7, 2, −5, −9, −14, −3, −1 with err=0; `done` at cycle 25.
- Error cases: DIV 5/0, MOD 5/0 and opcode 12 → result 0 with `result_err`=1 for each; no hang.
- Wrap-around and back-pressure: `start_ptr`=30, `num_instr`=4 → `result_ptr` 30, 31, 0, 1; with `result_ready` low for 5 cycles on the 2nd result, `result` stays stable and `result_valid` stays high.
- Edge sizes: `num_instr`=0 → `done` pulse the cycle after `start`, `result_valid` never asserted. MULT 32'h7FFFFFFF*32'h7FFFFFFF → 64'h3FFFFFFF00000001. ADD 32'h7FFFFFFF+1 → 64'h0000000080000000.
- Ignored start: `start` pulsed while `busy` → the run in flight is unaffected and no second run begins.
